// File: rtl/hpdl_pkg.sv
// hpdl_pkg: shared definitions for the HPDL-1414 text writer.
//   - hpdl_state_t : controller/strobe state encoding
//   - ASCII_*      : control characters interpreted by the writer
//   - DEF_*_CYC    : default strobe timing in clock cycles
//   - helpers      : character classification/folding, digit address
package hpdl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        PULSE      = 3'd2,
        HOLD       = 3'd3,
        CLEAR_NEXT = 3'd4
    } hpdl_state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_PULSE_CYC = 4;
    localparam int DEF_HOLD_CYC  = 2;

    // A zero-length phase would make the strobe sequence degenerate.
    function automatic int at_least_one(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    // Printable range the display can show (lower case is folded).
    function automatic logic is_writable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    // Only meaningful for writable bytes: 0x60-0x7E fold onto 0x40-0x5E.
    function automatic logic [6:0] fold_char(input logic [7:0] b);
        logic [6:0] lo;
        lo = b[6:0];
        return (lo[6:5] == 2'b11) ? (lo - 7'h20) : lo;
    endfunction

    // Device address 0 is the rightmost digit, cursor 0 the leftmost.
    function automatic logic [1:0] digit_addr(input logic [3:0] cursor);
        return 2'd3 - cursor[1:0];
    endfunction

endpackage

// File: rtl/hpdl_wr_strobe.sv
// hpdl_wr_strobe: SETUP -> PULSE -> HOLD write-strobe sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a sequence (honoured only while phase == IDLE)
//   done       : high in the last HOLD cycle
//   strobe     : registered, high exactly during PULSE
//   phase      : current sequencer state (IDLE/SETUP/PULSE/HOLD)
module hpdl_wr_strobe
    import hpdl_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    output logic        strobe,
    output hpdl_state_t phase
);

    localparam int S_N    = at_least_one(SETUP_CYC);
    localparam int P_N    = at_least_one(PULSE_CYC);
    localparam int H_N    = at_least_one(HOLD_CYC);
    localparam int SP_MAX = (S_N > P_N) ? S_N : P_N;
    localparam int MAX_N  = (SP_MAX > H_N) ? SP_MAX : H_N;
    localparam int CW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CW-1:0] S_LAST = CW'(S_N - 1);
    localparam logic [CW-1:0] P_LAST = CW'(P_N - 1);
    localparam logic [CW-1:0] H_LAST = CW'(H_N - 1);

    hpdl_state_t   phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            strobe_q <= (phase_d == PULSE);
        end
    end

    // Each phase counts 0..N-1 and clears the counter on exit.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + CW'(1);
        done    = 1'b0;
        case (phase_q)
            IDLE: begin
                cnt_d = '0;
                if (start) phase_d = SETUP;
            end
            SETUP: begin
                if (cnt_q == S_LAST) begin
                    phase_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == P_LAST) begin
                    phase_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == H_LAST) begin
                    phase_d = IDLE;
                    cnt_d   = '0;
                    done    = 1'b1;
                end
            end
            default: begin
                phase_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign strobe = strobe_q;
    assign phase  = phase_q;

endmodule

// File: rtl/hpdl_text_writer.sv
// hpdl_text_writer: streams received bytes onto four HPDL-1414 displays
// (16 digits) with cursor handling and a clear-screen sequence.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   rx_data, rx_valid  : byte stream from the UART receiver
//   rx_ready           : byte accepted when rx_valid && rx_ready
//   hpdl_d[6:0]        : shared display data bus
//   hpdl_a[1:0]        : shared digit address (0 = rightmost digit)
//   hpdl_wr_n[3:0]     : active-low write enable, one per display
//   busy               : write or clear sequence in progress
// Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
// are both high; rx_ready depends only on internal state, never on rx_valid.
module hpdl_text_writer
    import hpdl_pkg::*;
#(
    parameter int SETUP_CYC      = DEF_SETUP_CYC,
    parameter int PULSE_CYC      = DEF_PULSE_CYC,
    parameter int HOLD_CYC       = DEF_HOLD_CYC,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [6:0] hpdl_d,
    output logic [1:0] hpdl_a,
    output logic [3:0] hpdl_wr_n,
    output logic       busy
);

    // ctrl_q only uses IDLE, SETUP (a strobe sequence is running) and
    // CLEAR_NEXT; the sequencer supplies the finer SETUP/PULSE/HOLD phase.
    hpdl_state_t ctrl_q, ctrl_d;
    hpdl_state_t phase;
    hpdl_state_t state;
    logic [3:0]  cursor_q, cursor_d;
    logic [6:0]  d_q, d_d;
    logic [1:0]  a_q, a_d;
    logic [1:0]  disp_q, disp_d;
    logic        init_q, init_d;
    logic        clearing_q, clearing_d;
    logic        start, done, strobe;
    logic        accept;

    hpdl_wr_strobe #(
        .SETUP_CYC(SETUP_CYC),
        .PULSE_CYC(PULSE_CYC),
        .HOLD_CYC (HOLD_CYC)
    ) u_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .done  (done),
        .strobe(strobe),
        .phase (phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= IDLE;
            cursor_q   <= '0;
            d_q        <= '0;
            a_q        <= '0;
            disp_q     <= '0;
            init_q     <= 1'b0;
            clearing_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            cursor_q   <= cursor_d;
            d_q        <= d_d;
            a_q        <= a_d;
            disp_q     <= disp_d;
            init_q     <= init_d;
            clearing_q <= clearing_d;
        end
    end

    // init_q keeps rx_ready low between reset release and the first edge.
    assign rx_ready = (ctrl_q == IDLE) && init_q;
    assign accept   = rx_valid && rx_ready;

    always_comb begin
        ctrl_d     = ctrl_q;
        cursor_d   = cursor_q;
        d_d        = d_q;
        a_d        = a_q;
        disp_d     = disp_q;
        init_d     = init_q;
        clearing_d = clearing_q;
        start      = 1'b0;
        case (ctrl_q)
            IDLE: begin
                if (!init_q) begin
                    init_d = 1'b1;
                    if (CLEAR_ON_RESET) begin
                        clearing_d = 1'b1;
                        cursor_d   = '0;
                        ctrl_d     = CLEAR_NEXT;
                    end
                end else if (accept) begin
                    if (is_writable(rx_data)) begin
                        start  = 1'b1;
                        d_d    = fold_char(rx_data);
                        a_d    = digit_addr(cursor_q);
                        disp_d = cursor_q[3:2];
                        ctrl_d = SETUP;
                    end else if (rx_data == ASCII_CR) begin
                        cursor_d = '0;
                    end else if (rx_data == ASCII_BS) begin
                        if (cursor_q != 4'd0) cursor_d = cursor_q - 4'd1;
                    end else if (rx_data == ASCII_FF) begin
                        clearing_d = 1'b1;
                        cursor_d   = '0;
                        ctrl_d     = CLEAR_NEXT;
                    end
                end
            end
            CLEAR_NEXT: begin
                start  = 1'b1;
                d_d    = ASCII_SPACE[6:0];
                a_d    = digit_addr(cursor_q);
                disp_d = cursor_q[3:2];
                ctrl_d = SETUP;
            end
            SETUP: begin
                // The clear loop reuses the write cursor; it ends when the
                // cursor wraps from 15 back to 0.
                if (done) begin
                    cursor_d = cursor_q + 4'd1;
                    if (clearing_q && (cursor_q != 4'd15)) begin
                        ctrl_d = CLEAR_NEXT;
                    end else begin
                        clearing_d = 1'b0;
                        ctrl_d     = IDLE;
                    end
                end
            end
            default: ctrl_d = IDLE;
        endcase
    end

    assign state     = (ctrl_q == SETUP) ? phase : ctrl_q;
    assign busy      = (state != IDLE);
    assign hpdl_d    = d_q;
    assign hpdl_a    = a_q;
    // strobe is a register cleared asynchronously, so reset releases the
    // enable at once without waiting for a clock edge.
    assign hpdl_wr_n = strobe ? ~(4'b0001 << disp_q) : 4'hF;

endmodule

// File: doc/hpdl_text_writer.md
HPDL_TEXT_WRITER -- requirements
Module: hpdl_text_writer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles that address/data are stable before the write strobe.
REQ-002 SHALL have parameter PULSE_CYC, default 4: cycles of the active-low write strobe (≥130 ns at 12 MHz).
REQ-003 SHALL have parameter HOLD_CYC, default 2: cycles that address/data are held after the strobe rises.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1: when 1, clear all 16 digits after reset.
REQ-005 SHALL have port clk, input, 1: single clock for the block.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port rx_data, input, 8: received byte from the upstream UART receiver.
REQ-008 SHALL have port rx_valid, input, 1: rx_data is valid.
REQ-009 SHALL have port rx_ready, output, 1: block accepts a byte this cycle.
REQ-010 SHALL have port hpdl_d, output, 7: HPDL-1414 data bus D6..D0.
REQ-011 SHALL have port hpdl_a, output, 2: HPDL-1414 digit address A1..A0.
REQ-012 SHALL have port hpdl_wr_n, output, 4: per-display active-low write enables, bit i = display i.
REQ-013 SHALL have port busy, output, 1: a write or clear sequence is in progress.

Function
REQ-014 SHALL accept a byte only on a cycle where rx_valid and rx_ready are both 1; rx_ready SHALL be 1 only in state IDLE.
REQ-015 SHALL have a 4-bit cursor, 0 = leftmost digit of display 0 and 15 = rightmost digit of display 3.
REQ-016 SHALL select the display as cursor[3:2] and drive hpdl_a = 3 - cursor[1:0], since A=0 is the device's rightmost digit.
REQ-017 SHALL write bytes 0x20-0x5F unchanged.
REQ-018 SHALL write bytes 0x60-0x7E as byte - 0x20 (upper-case fold).
REQ-019 After each write, the cursor SHALL increment, wrapping from 15 to 0.
REQ-020 On 0x0D (CR), SHALL set the cursor to 0 with no write; occupies 1 cycle, and rx_ready returns the next cycle.
REQ-021 On 0x08 (BS), SHALL decrement the cursor, saturating at 0, with no write.
REQ-022 On 0x0C (FF), SHALL run CLEAR: write 0x20 to positions 0..15 in order, then set the cursor to 0.
REQ-023 SHALL consume all other bytes (0x00-0x1F except the above, and 0x7F-0xFF) with no effect.
REQ-024 SHALL implement states IDLE, SETUP, PULSE, HOLD and CLEAR_NEXT:
- IDLE -> SETUP on a writable byte.
- SETUP -> PULSE after SETUP_CYC cycles.
- PULSE -> HOLD after PULSE_CYC cycles.
- HOLD -> IDLE after HOLD_CYC cycles, or HOLD -> CLEAR_NEXT while clearing.
- CLEAR_NEXT -> SETUP for the next position.
REQ-025 SHALL latch hpdl_d and hpdl_a in the cycle after acceptance and hold them stable through the end of HOLD.
REQ-026 Exactly one hpdl_wr_n bit SHALL be 0, and only during PULSE.
REQ-027 For a single write accepted at cycle 0, SHALL have:
- hpdl_wr_n low during cycles 1+SETUP_CYC .. SETUP_CYC+PULSE_CYC;
- rx_ready = 1 again at cycle SETUP_CYC+PULSE_CYC+HOLD_CYC+1.
REQ-028 busy SHALL equal the inverse of (state == IDLE).
REQ-029 hpdl_d and hpdl_a SHALL keep their last value in IDLE.
REQ-030 Each timing counter SHALL be wide enough for its parameter; a parameter of 0 SHALL be treated as 1.

Reset
REQ-031 On rst_n low, SHALL asynchronously set: state IDLE, cursor 0, hpdl_wr_n 4'b1111, hpdl_d 0, hpdl_a 0, rx_ready 0, busy 0.
REQ-032 After rst_n rises, with CLEAR_ON_RESET=1, SHALL start CLEAR on the first clock (busy 1, rx_ready 0); with 0, SHALL enter IDLE with rx_ready 1.
REQ-033 Reset mid-strobe SHALL force hpdl_wr_n high immediately and abandon the sequence; no partial state SHALL survive.

Structure
REQ-034 Package hpdl_pkg SHALL hold:
- the state encoding;
- ASCII constants CR, BS, FF, SPACE;
- default timing values.
REQ-035 Sub-module hpdl_wr_strobe SHALL implement the SETUP/PULSE/HOLD sequencing: start in, done out, strobe out.
REQ-036 The parent block SHALL own the cursor, character mapping and CLEAR loop.

Verification
REQ-037 Reset with CLEAR_ON_RESET=1 -> 16 strobes with hpdl_d=0x20, display/address order (0,3),(0,2)..(3,0), then rx_ready=1 and cursor 0.
REQ-038 Send 'a' (0x61) at cursor 0 -> hpdl_d=0x41, hpdl_a=3, hpdl_wr_n=4'b1110 low for exactly 4 cycles, rx_ready back 9 cycles after acceptance.
REQ-039 Send 17 bytes 'A' -> writes 1..16 hit cursor 0..15, write 17 hits cursor 0 (display 0, A=3).
REQ-040 Sequence BS at cursor 0, then 'B','C', CR, 'D' -> no write for BS; 'D' is written at cursor 0.
REQ-041 Hold rx_valid=1 during a write -> no acceptance until IDLE; no byte lost or duplicated; 0x07 and 0x80 produce no strobe.
REQ-042 Drop rst_n mid-PULSE -> hpdl_wr_n=4'b1111 in the same cycle, no clock edge needed.
